seq_sum_scheduler: RTL
======================

// Module: seq_sum_scheduler
// PURPOSE
//   Time-multiplexed pairwise-sum engine: one shared DATA_W-bit adder computes,
//   in three sequenced cycles, one+two, one+three and three+two.
//   Replaces three parallel adders where area matters; sits between an operand
//   producer and a sum consumer with valid/ready handshakes on both sides.
// PARAMETERS
//   DATA_W   8   operand and sum width (sums wrap modulo 2^DATA_W)
// PORTS
//   clk          in   1        rising-edge clock, single clock domain
//   rst          in   1        synchronous, active-high reset
//   in_valid     in   1        operand triple valid
//   in_ready     out  1        block can accept a triple (state IDLE)
//   data_one     in   DATA_W   operand one
//   data_two     in   DATA_W   operand two
//   data_three   in   DATA_W   operand three
//   out_valid    out  1        sum results valid, held until accepted
//   out_ready    in   1        consumer accepts results
//   sum_one      out  DATA_W   data_one + data_two   (low DATA_W bits)
//   sum_two      out  DATA_W   data_one + data_three (low DATA_W bits)
//   sum_three    out  DATA_W   data_three + data_two (low DATA_W bits)
//   sum_cout     out  3        carry-out of sum_three, sum_two, sum_one ([2],[1],[0])
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. All state changes on
//     the rising edge of clk.
//   - Reset, and reset asserted mid-operation: state=IDLE; out_valid=0;
//     sum_one/two/three=0; sum_cout=0; captured operands=0. In-flight work is
//     discarded and no out_valid pulse is produced.
//   - in_ready is combinational: 1 iff state==IDLE and rst==0.
//   - FSM: IDLE -> S1 -> S2 -> S3 -> DONE -> IDLE.
//     IDLE: on in_valid&&in_ready, capture data_one/two/three into internal regs,
//           go S1. Otherwise stay.
//     S1: shared adder = op1+op2 -> sum_one, carry -> sum_cout[0]; go S2.
//     S2: shared adder = op1+op3 -> sum_two, carry -> sum_cout[1]; go S3.
//     S3: shared adder = op3+op2 -> sum_three, carry -> sum_cout[2];
//         set out_valid=1; go DONE.
//     DONE: hold all outputs stable; on out_ready, clear out_valid, go IDLE.
//   - Exactly one DATA_W+1-bit adder instance; operand mux driven by state.
//   - Latency: accept on edge E0 -> out_valid high after E3 (3 clocks).
//     Earliest next accept is the edge after out_ready is sampled in DONE;
//     max throughput one triple per 5 clocks.
//   - Inputs changing after capture have no effect on the current job.
//   - in_valid while not IDLE: ignored (in_ready=0); producer must hold it.
//   - out_ready while out_valid=0: ignored.
//   - sum_one/two update during S1/S2 are visible early, but are only
//     defined valid while out_valid=1.
//   - Width rule: each sum is low DATA_W bits of the DATA_W+1-bit result;
//     bit DATA_W goes to the matching sum_cout bit.
// TESTING
//   1. rst=1 two cycles with random inputs -> all outputs 0, in_ready=0 during
//      rst, in_ready=1 after.
//   2. Accept one=8'd10,two=8'd20,three=8'd30 -> 3 clocks later out_valid=1,
//      sums 30/40/50, sum_cout=3'b000.
//   3. one=8'hF0,two=8'h20,three=8'h10 -> sums 8'h10/8'h00/8'h30,
//      sum_cout=3'b011.
//   4. Hold out_ready=0 for 10 cycles after out_valid -> outputs stable,
//      in_ready=0; change data_* and pulse in_valid -> no effect.
//   5. Assert rst in S2 -> next cycle IDLE, all outputs 0, no out_valid ever
//      for that job.
//   6. Back-to-back jobs with out_ready=1 and in_valid held -> new accept every
//      5 clocks, each result matches its own captured triple.

Source files
------------

// File: rtl/seq_sum_if.sv
// Handshake bundle between operand producer, pairwise-sum engine and sum consumer.
// The engine attaches through the slave modport; the driving side uses master.
interface seq_sum_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_one;
    logic [DATA_W-1:0] data_two;
    logic [DATA_W-1:0] data_three;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum_one;
    logic [DATA_W-1:0] sum_two;
    logic [DATA_W-1:0] sum_three;
    logic [2:0]        sum_cout;

    modport slave (
        input  in_valid, data_one, data_two, data_three, out_ready,
        output in_ready, out_valid, sum_one, sum_two, sum_three, sum_cout
    );

    modport master (
        output in_valid, data_one, data_two, data_three, out_ready,
        input  in_ready, out_valid, sum_one, sum_two, sum_three, sum_cout
    );
endinterface

// File: rtl/seq_sum_scheduler.sv
// Time-multiplexed pairwise-sum engine: one shared DATA_W+1-bit adder produces
// one+two, one+three and three+two over three sequenced cycles.
module seq_sum_scheduler #(
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_sum_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [DATA_W-1:0] sum1_q, sum1_d, sum2_q, sum2_d, sum3_q, sum3_d;
    logic [2:0]        cout_q, cout_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready;
    logic [DATA_W-1:0] add_a, add_b;
    logic [DATA_W:0]   add_res;

    // Carry lands in the top bit; the low DATA_W bits are the wrapped sum.
    function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;

    // Operand mux for the single shared adder, steered by the sequencing state.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            S1:      begin add_a = op1_q; add_b = op2_q; end
            S2:      begin add_a = op1_q; add_b = op3_q; end
            S3:      begin add_a = op3_q; add_b = op2_q; end
            default: ;
        endcase
        add_res = add_wide(add_a, add_b);
    end

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        op3_d       = op3_q;
        sum1_d      = sum1_q;
        sum2_d      = sum2_q;
        sum3_d      = sum3_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    op1_d   = bus.data_one;
                    op2_d   = bus.data_two;
                    op3_d   = bus.data_three;
                    state_d = S1;
                end
            end
            S1: begin
                sum1_d    = add_res[DATA_W-1:0];
                cout_d[0] = add_res[DATA_W];
                state_d   = S2;
            end
            S2: begin
                sum2_d    = add_res[DATA_W-1:0];
                cout_d[1] = add_res[DATA_W];
                state_d   = S3;
            end
            S3: begin
                sum3_d      = add_res[DATA_W-1:0];
                cout_d[2]   = add_res[DATA_W];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears results and captured operands too, so an aborted job leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            op3_q       <= '0;
            sum1_q      <= '0;
            sum2_q      <= '0;
            sum3_q      <= '0;
            cout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op3_q       <= op3_d;
            sum1_q      <= sum1_d;
            sum2_q      <= sum2_d;
            sum3_q      <= sum3_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_one   = sum1_q;
    assign bus.sum_two   = sum2_q;
    assign bus.sum_three = sum3_q;
    assign bus.sum_cout  = cout_q;

endmodule
